// File: rtl/conv_pe_array_if.sv
// Beat-stream bus between the layer controller and the conv PE array.
// The controller side drives the operands; the array returns results and status.
interface conv_pe_array_if #(
    parameter int CPF     = 8,
    parameter int KPF     = 4,
    parameter int DIN_DW  = 16,
    parameter int WW      = 16,
    parameter int BIAS_DW = 16,
    parameter int DOUT_DW = 16
);
    logic                     op_din_en;
    logic                     op_din_eop;
    logic [CPF*DIN_DW-1:0]    op_din;
    logic [KPF*CPF*WW-1:0]    op_weight;
    logic [KPF*BIAS_DW-1:0]   op_bias;
    logic [KPF*DOUT_DW-1:0]   op_dout;
    logic                     op_dout_en;
    logic                     sat_flag;

    modport master (
        output op_din_en, op_din_eop, op_din, op_weight, op_bias,
        input  op_dout, op_dout_en, sat_flag
    );

    modport slave (
        input  op_din_en, op_din_eop, op_din, op_weight, op_bias,
        output op_dout, op_dout_en, sat_flag
    );
endinterface

// File: rtl/conv_pe_array.sv
// KPF-lane signed MAC array: products, lane sum, frame accumulate, then
// bias/round/activate/saturate into a strobed output with a sticky saturation flag.
module conv_pe_array #(
    parameter int CPF       = 8,
    parameter int KPF       = 4,
    parameter int DIN_DW    = 16,
    parameter int WW        = 16,
    parameter int BIAS_DW   = 16,
    parameter int DOUT_DW   = 16,
    parameter int ACC_WIDTH = 40,
    parameter int DIN_Q     = 6,
    parameter int W_Q       = 13,
    parameter int BIAS_Q    = 6,
    parameter int DOUT_Q    = 6,
    parameter int ACT_MODE  = 1
) (
    input logic           clk,
    input logic           rst,
    conv_pe_array_if.slave bus
);
    localparam int PROD_W = DIN_DW + WW;
    localparam int SH     = DIN_Q + W_Q - DOUT_Q;
    localparam int BSH    = DIN_Q + W_Q - BIAS_Q;
    localparam int T_W    = ACC_WIDTH + 2;
    localparam logic signed [T_W-1:0] RND  = T_W'(64'sd1 <<< (SH - 1));
    localparam logic signed [T_W-1:0] MAXV = T_W'((64'sd1 <<< (DOUT_DW - 1)) - 64'sd1);
    localparam logic signed [T_W-1:0] MINV = ~MAXV;

    logic                        first_q;
    logic                        v1, e1, f1;
    logic signed [PROD_W-1:0]    prod1 [KPF][CPF];
    logic signed [BIAS_DW-1:0]   bias1 [KPF];
    logic signed [ACC_WIDTH-1:0] sum_c [KPF];
    logic                        v2, e2, f2;
    logic signed [ACC_WIDTH-1:0] sum2  [KPF];
    logic signed [BIAS_DW-1:0]   bias2 [KPF];
    logic                        v3, e3;
    logic signed [ACC_WIDTH-1:0] acc3  [KPF];
    logic signed [BIAS_DW-1:0]   bias3 [KPF];
    logic [DOUT_DW-1:0]          res4  [KPF];
    logic [KPF-1:0]              clip4;
    logic [KPF*DOUT_DW-1:0]      dout_q;
    logic                        dout_en_q;
    logic                        sat_q;

    // Returns {clipped, value}; the two extra bits of T_W keep the bias add and rounding exact.
    function automatic logic [DOUT_DW:0] finish_lane(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic signed [BIAS_DW-1:0]   bias
    );
        logic signed [T_W-1:0] b, t, r, a;
        b = T_W'(bias);
        b = b <<< BSH;
        t = T_W'(acc) + b;
        r = (t + RND) >>> SH;
        a = r;
        if (ACT_MODE == 1 && r[T_W-1]) begin
            a = '0;
        end else if (ACT_MODE == 2 && r[T_W-1]) begin
            a = r >>> 3;
        end
        if (a > MAXV) begin
            finish_lane = {1'b1, MAXV[DOUT_DW-1:0]};
        end else if (a < MINV) begin
            finish_lane = {1'b1, MINV[DOUT_DW-1:0]};
        end else begin
            finish_lane = {1'b0, a[DOUT_DW-1:0]};
        end
    endfunction

    // S1: products and bias; flags only move on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= 1'b1;
            v1      <= 1'b0;
            e1      <= 1'b0;
            f1      <= 1'b0;
            for (int k = 0; k < KPF; k++) begin
                bias1[k] <= '0;
                for (int c = 0; c < CPF; c++) begin
                    prod1[k][c] <= '0;
                end
            end
        end else begin
            v1 <= bus.op_din_en;
            e1 <= bus.op_din_en & bus.op_din_eop;
            f1 <= first_q;
            if (bus.op_din_en) begin
                first_q <= bus.op_din_eop;
            end
            for (int k = 0; k < KPF; k++) begin
                bias1[k] <= bus.op_bias[k*BIAS_DW +: BIAS_DW];
                for (int c = 0; c < CPF; c++) begin
                    prod1[k][c] <= PROD_W'($signed(bus.op_din[c*DIN_DW +: DIN_DW]))
                                 * PROD_W'($signed(bus.op_weight[(k*CPF+c)*WW +: WW]));
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < KPF; k++) begin
            sum_c[k] = '0;
            for (int c = 0; c < CPF; c++) begin
                sum_c[k] = sum_c[k] + ACC_WIDTH'(prod1[k][c]);
            end
        end
    end

    // S2 registers the lane sums; S3 restarts the accumulator on a frame's first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            e2 <= 1'b0;
            f2 <= 1'b0;
            v3 <= 1'b0;
            e3 <= 1'b0;
            for (int k = 0; k < KPF; k++) begin
                sum2[k]  <= '0;
                bias2[k] <= '0;
                acc3[k]  <= '0;
                bias3[k] <= '0;
            end
        end else begin
            v2 <= v1;
            e2 <= e1;
            f2 <= f1;
            v3 <= v2;
            e3 <= e2;
            for (int k = 0; k < KPF; k++) begin
                sum2[k]  <= sum_c[k];
                bias2[k] <= bias1[k];
                bias3[k] <= bias2[k];
                if (v2) begin
                    acc3[k] <= f2 ? sum2[k] : acc3[k] + sum2[k];
                end
            end
        end
    end

    always_comb begin
        clip4 = '0;
        for (int k = 0; k < KPF; k++) begin
            {clip4[k], res4[k]} = finish_lane(acc3[k], bias3[k]);
        end
    end

    // S4: the result register only loads on a frame-ending beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            dout_en_q <= v3 & e3;
            if (v3 && e3) begin
                for (int k = 0; k < KPF; k++) begin
                    dout_q[k*DOUT_DW +: DOUT_DW] <= res4[k];
                end
                if (|clip4) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign bus.op_dout    = dout_q;
    assign bus.op_dout_en = dout_en_q;
    assign bus.sat_flag   = sat_q;
endmodule

// File: tb/tb_conv_pe_array.sv
// Bench for conv_pe_array: three instances (activation modes 0/1/2) share one stimulus
// stream and are checked against a frame-level arithmetic model plus a directed table.
module tb_conv_pe_array;
    localparam int CPF = 8, KPF = 4, DIN_DW = 16, WW = 16, BIAS_DW = 16, DOUT_DW = 16;
    localparam int ACC_WIDTH = 40, DIN_Q = 6, W_Q = 13, BIAS_Q = 6, DOUT_Q = 6;
    localparam int SH  = DIN_Q + W_Q - DOUT_Q;
    localparam int BSH = DIN_Q + W_Q - BIAS_Q;

    typedef logic [CPF*DIN_DW-1:0]  din_t;
    typedef logic [KPF*CPF*WW-1:0]  wgt_t;
    typedef logic [KPF*BIAS_DW-1:0] bias_t;
    typedef logic [KPF*DOUT_DW-1:0] dout_t;

    typedef struct {
        din_t            din;
        wgt_t            wgt;
        bias_t           bias;
        logic [2:0][KPF*DOUT_DW-1:0] exp;
        logic [2:0]      exp_sat;
    } tvec_t;

    typedef struct {
        int                           due;
        logic [2:0][KPF*DOUT_DW-1:0]  res;
        logic [2:0]                   clip;
    } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en, eop;
    din_t din;
    wgt_t wgt;
    bias_t bias;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int dut_strobes = 0;

    dout_t      dout_w [3];
    logic [2:0] dout_en_w, sat_w;

    longint     macc [KPF];
    bit         mfirst;
    pend_t      exp_q [$];
    dout_t      held [3];
    logic [2:0] msat;
    logic       strobe_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_pe_array_if #(.CPF(CPF), .KPF(KPF), .DIN_DW(DIN_DW), .WW(WW), .BIAS_DW(BIAS_DW), .DOUT_DW(DOUT_DW)) bus0 ();
    conv_pe_array_if #(.CPF(CPF), .KPF(KPF), .DIN_DW(DIN_DW), .WW(WW), .BIAS_DW(BIAS_DW), .DOUT_DW(DOUT_DW)) bus1 ();
    conv_pe_array_if #(.CPF(CPF), .KPF(KPF), .DIN_DW(DIN_DW), .WW(WW), .BIAS_DW(BIAS_DW), .DOUT_DW(DOUT_DW)) bus2 ();

    assign bus0.op_din_en = en;  assign bus0.op_din_eop = eop;  assign bus0.op_din = din;
    assign bus0.op_weight = wgt; assign bus0.op_bias = bias;
    assign bus1.op_din_en = en;  assign bus1.op_din_eop = eop;  assign bus1.op_din = din;
    assign bus1.op_weight = wgt; assign bus1.op_bias = bias;
    assign bus2.op_din_en = en;  assign bus2.op_din_eop = eop;  assign bus2.op_din = din;
    assign bus2.op_weight = wgt; assign bus2.op_bias = bias;

    assign dout_w[0] = bus0.op_dout; assign dout_en_w[0] = bus0.op_dout_en; assign sat_w[0] = bus0.sat_flag;
    assign dout_w[1] = bus1.op_dout; assign dout_en_w[1] = bus1.op_dout_en; assign sat_w[1] = bus1.sat_flag;
    assign dout_w[2] = bus2.op_dout; assign dout_en_w[2] = bus2.op_dout_en; assign sat_w[2] = bus2.sat_flag;

    conv_pe_array #(.CPF(CPF), .KPF(KPF), .DIN_DW(DIN_DW), .WW(WW), .BIAS_DW(BIAS_DW), .DOUT_DW(DOUT_DW),
        .ACC_WIDTH(ACC_WIDTH), .DIN_Q(DIN_Q), .W_Q(W_Q), .BIAS_Q(BIAS_Q), .DOUT_Q(DOUT_Q), .ACT_MODE(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    conv_pe_array #(.CPF(CPF), .KPF(KPF), .DIN_DW(DIN_DW), .WW(WW), .BIAS_DW(BIAS_DW), .DOUT_DW(DOUT_DW),
        .ACC_WIDTH(ACC_WIDTH), .DIN_Q(DIN_Q), .W_Q(W_Q), .BIAS_Q(BIAS_Q), .DOUT_Q(DOUT_Q), .ACT_MODE(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    conv_pe_array #(.CPF(CPF), .KPF(KPF), .DIN_DW(DIN_DW), .WW(WW), .BIAS_DW(BIAS_DW), .DOUT_DW(DOUT_DW),
        .ACC_WIDTH(ACC_WIDTH), .DIN_Q(DIN_Q), .W_Q(W_Q), .BIAS_Q(BIAS_Q), .DOUT_Q(DOUT_Q), .ACT_MODE(2))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        if (n >= 0) return n / d;
        return -((-n + d - 1) / d);
    endfunction

    function automatic longint beat_sum(input int k, input din_t d, input wgt_t w);
        longint s;
        logic signed [DIN_DW-1:0] x;
        logic signed [WW-1:0] y;
        s = 0;
        for (int c = 0; c < CPF; c++) begin
            x = d[c*DIN_DW +: DIN_DW];
            y = w[(k*CPF+c)*WW +: WW];
            s += longint'(x) * longint'(y);
        end
        return s;
    endfunction

    // Fixed-point result of one lane: value = acc + bias, rounded half up to the output scale.
    function automatic logic [DOUT_DW:0] model_finish(input longint acc, input longint b, input int mode);
        longint t, r, hi, lo;
        logic [DOUT_DW-1:0] v;
        t  = acc + b * (longint'(1) <<< BSH);
        r  = floor_div(t + (longint'(1) <<< (SH - 1)), longint'(1) <<< SH);
        if (mode == 1 && r < 0) r = 0;
        if (mode == 2 && r < 0) r = floor_div(r, 8);
        hi = (longint'(1) <<< (DOUT_DW - 1)) - 1;
        lo = -hi - 1;
        if (r > hi) begin
            v = DOUT_DW'(hi);
            return {1'b1, v};
        end
        if (r < lo) begin
            v = DOUT_DW'(lo);
            return {1'b1, v};
        end
        v = DOUT_DW'(r);
        return {1'b0, v};
    endfunction

    function automatic void modelReset();
        mfirst = 1'b1;
        for (int k = 0; k < KPF; k++) macc[k] = 0;
        exp_q.delete();
        for (int m = 0; m < 3; m++) held[m] = '0;
        msat = '0;
    endfunction

    task automatic applyStimulus(input logic e, input logic p, input din_t d, input wgt_t w, input bias_t b);
        pend_t pe;
        logic [DOUT_DW:0] f;
        longint s;
        @(posedge clk);
        #1;
        en = e; eop = p; din = d; wgt = w; bias = b;
        if (e) begin
            for (int k = 0; k < KPF; k++) begin
                s = beat_sum(k, d, w);
                macc[k] = mfirst ? s : macc[k] + s;
            end
            mfirst = p;
            if (p) begin
                pe.due  = cyc + 4;
                pe.res  = '0;
                pe.clip = '0;
                for (int m = 0; m < 3; m++) begin
                    for (int k = 0; k < KPF; k++) begin
                        f = model_finish(macc[k], longint'($signed(b[k*BIAS_DW +: BIAS_DW])), m);
                        pe.res[m][k*DOUT_DW +: DOUT_DW] = f[DOUT_DW-1:0];
                        if (f[DOUT_DW]) pe.clip[m] = 1'b1;
                    end
                end
                exp_q.push_back(pe);
            end
        end
    endtask

    function automatic din_t rand_din();
        din_t d;
        for (int c = 0; c < CPF; c++) d[c*DIN_DW +: DIN_DW] = DIN_DW'($urandom);
        return d;
    endfunction

    function automatic wgt_t rand_wgt();
        wgt_t w;
        for (int i = 0; i < KPF*CPF; i++) w[i*WW +: WW] = WW'($urandom);
        return w;
    endfunction

    function automatic bias_t rand_bias();
        bias_t b;
        for (int k = 0; k < KPF; k++) b[k*BIAS_DW +: BIAS_DW] = BIAS_DW'($urandom);
        return b;
    endfunction

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), rand_din(), rand_wgt(), rand_bias());
        end
    endtask

    task automatic resetPulse();
        @(posedge clk);
        #1;
        rst = 1'b1; en = 1'b0; eop = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic din_t fill_din(input int v);
        din_t d;
        for (int c = 0; c < CPF; c++) d[c*DIN_DW +: DIN_DW] = DIN_DW'(v);
        return d;
    endfunction

    function automatic wgt_t fill_lane(input int k, input int v);
        wgt_t w;
        w = '0;
        for (int c = 0; c < CPF; c++) w[(k*CPF+c)*WW +: WW] = WW'(v);
        return w;
    endfunction

    function automatic wgt_t fill_wgt_all(input int v);
        wgt_t w;
        for (int i = 0; i < KPF*CPF; i++) w[i*WW +: WW] = WW'(v);
        return w;
    endfunction

    function automatic dout_t lanes(input int a, input int b, input int c, input int d);
        return {DOUT_DW'(d), DOUT_DW'(c), DOUT_DW'(b), DOUT_DW'(a)};
    endfunction

    // Cycle-by-cycle scoreboard: strobe timing, held output and sticky flag for every mode.
    always @(negedge clk) begin
        strobe_exp = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        if (strobe_exp) begin
            for (int m = 0; m < 3; m++) held[m] = exp_q[0].res[m];
            msat = msat | exp_q[0].clip;
            void'(exp_q.pop_front());
        end
        for (int m = 0; m < 3; m++) begin
            checkOutput($sformatf("mon_strobe_m%0d_cyc%0d", m, cyc), 64'(dout_en_w[m]), 64'(strobe_exp));
            checkOutput($sformatf("mon_dout_m%0d_cyc%0d", m, cyc), 64'(dout_w[m]), 64'(held[m]));
            checkOutput($sformatf("mon_sat_m%0d_cyc%0d", m, cyc), 64'(sat_w[m]), 64'(msat[m]));
        end
        if (dout_en_w[1]) dut_strobes++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tvec_t tbl [6];
        int    c0;
        int    flen;
        logic  p;

        en = 1'b0; eop = 1'b0; din = '0; wgt = '0; bias = '0;
        modelReset();

        tbl[0].din = fill_din(64);  tbl[0].wgt = fill_lane(0, 8192);  tbl[0].bias = '0;
        tbl[0].exp = {lanes(512, 0, 0, 0), lanes(512, 0, 0, 0), lanes(512, 0, 0, 0)};
        tbl[0].exp_sat = 3'b000;
        tbl[1].din = fill_din(64);  tbl[1].wgt = fill_lane(0, -8192); tbl[1].bias = '0;
        tbl[1].exp = {lanes(-64, 0, 0, 0), lanes(0, 0, 0, 0), lanes(-512, 0, 0, 0)};
        tbl[1].exp_sat = 3'b000;
        tbl[2].din = '0; tbl[2].din[DIN_DW-1:0] = 16'd1;
        tbl[2].wgt = '0; tbl[2].wgt[WW-1:0] = 16'd4096;
        tbl[2].bias = '0; tbl[2].bias[BIAS_DW-1:0] = 16'd64;
        tbl[2].exp = {lanes(65, 0, 0, 0), lanes(65, 0, 0, 0), lanes(65, 0, 0, 0)};
        tbl[2].exp_sat = 3'b000;
        tbl[3].din = '0; tbl[3].wgt = '0; tbl[3].bias = {16'd0, 16'hffff, 16'hffc0, 16'd0};
        tbl[3].exp = {lanes(0, -8, -1, 0), lanes(0, 0, 0, 0), lanes(0, -64, -1, 0)};
        tbl[3].exp_sat = 3'b000;
        tbl[4].din = fill_din(64);  tbl[4].wgt = fill_lane(3, 8192) | fill_lane(2, 4096); tbl[4].bias = '0;
        tbl[4].exp = {lanes(0, 0, 256, 512), lanes(0, 0, 256, 512), lanes(0, 0, 256, 512)};
        tbl[4].exp_sat = 3'b000;
        tbl[5].din = fill_din(-32768); tbl[5].wgt = fill_lane(0, 32767); tbl[5].bias = '0;
        tbl[5].exp = {lanes(-32768, 0, 0, 0), lanes(0, 0, 0, 0), lanes(-32768, 0, 0, 0)};
        tbl[5].exp_sat = 3'b101;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int m = 0; m < 3; m++) begin
            checkOutput($sformatf("reset_dout_m%0d", m), 64'(dout_w[m]), 64'd0);
            checkOutput($sformatf("reset_en_m%0d", m), 64'(dout_en_w[m]), 64'd0);
            checkOutput($sformatf("reset_sat_m%0d", m), 64'(sat_w[m]), 64'd0);
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, tbl[i].din, tbl[i].wgt, tbl[i].bias);
            idleCycles(4);
            for (int m = 0; m < 3; m++) begin
                checkOutput($sformatf("tbl%0d_en_m%0d", i, m), 64'(dout_en_w[m]), 64'd1);
                checkOutput($sformatf("tbl%0d_dout_m%0d", i, m), 64'(dout_w[m]), 64'(tbl[i].exp[m]));
                checkOutput($sformatf("tbl%0d_sat_m%0d", i, m), 64'(sat_w[m]), 64'(tbl[i].exp_sat[m]));
            end
        end

        // Positive saturation over a 4-beat frame, then stickiness and clear on reset.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'(i == 3), fill_din(32767), fill_wgt_all(32767), '0);
        end
        idleCycles(4);
        for (int m = 0; m < 3; m++) begin
            checkOutput($sformatf("satpos_dout_m%0d", m), 64'(dout_w[m]), 64'(lanes(32767, 32767, 32767, 32767)));
            checkOutput($sformatf("satpos_sat_m%0d", m), 64'(sat_w[m]), 64'd1);
        end
        applyStimulus(1'b1, 1'b1, fill_din(64), fill_lane(0, 8192), '0);
        idleCycles(4);
        checkOutput("sat_after_clean_dout", 64'(dout_w[1]), 64'(lanes(512, 0, 0, 0)));
        checkOutput("sat_sticky", 64'(sat_w), 64'(3'b111));
        resetPulse();
        checkOutput("sat_cleared", 64'(sat_w), 64'd0);

        // Back-to-back frames: 3-beat A, then single-beat B with no carry-over.
        applyStimulus(1'b1, 1'b0, fill_din(64), fill_lane(0, 8192), '0);
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, fill_din(64), fill_lane(0, 8192), '0);
        applyStimulus(1'b1, 1'b1, fill_din(64), fill_lane(0, 8192), '0);
        applyStimulus(1'b1, 1'b1, fill_din(64), fill_lane(0, 4096), '0);
        idleCycles(3);
        checkOutput("b2b_cycle_a", 64'(cyc - c0), 64'd6);
        checkOutput("b2b_strobe_a", 64'(dout_en_w[1]), 64'd1);
        checkOutput("b2b_dout_a", 64'(dout_w[1]), 64'(lanes(1536, 0, 0, 0)));
        idleCycles(1);
        checkOutput("b2b_strobe_b", 64'(dout_en_w[1]), 64'd1);
        checkOutput("b2b_dout_b", 64'(dout_w[1]), 64'(lanes(256, 0, 0, 0)));
        idleCycles(1);
        checkOutput("b2b_strobe_end", 64'(dout_en_w[1]), 64'd0);
        checkOutput("b2b_hold", 64'(dout_w[1]), 64'(lanes(256, 0, 0, 0)));

        // Reset mid-frame discards the partial frame.
        dut_strobes = 0;
        applyStimulus(1'b1, 1'b0, fill_din(64), fill_lane(0, 8192), '0);
        applyStimulus(1'b1, 1'b0, fill_din(64), fill_lane(0, 8192), '0);
        resetPulse();
        checkOutput("rstmid_dout_zero", 64'(dout_w[1]), 64'd0);
        applyStimulus(1'b1, 1'b1, fill_din(64), fill_lane(0, 8192), '0);
        idleCycles(6);
        checkOutput("rstmid_strobes", 64'(dut_strobes), 64'd1);
        checkOutput("rstmid_dout", 64'(dout_w[1]), 64'(lanes(512, 0, 0, 0)));

        // Random frames against the model, with one reset in the middle.
        flen = 0;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                resetPulse();
                flen = 0;
            end
            if ($urandom_range(0, 6) == 0) begin
                idleCycles(1);
            end else begin
                p = ($urandom_range(0, 2) == 0) || (flen == 7);
                applyStimulus(1'b1, p, rand_din(), rand_wgt(), rand_bias());
                flen = p ? 0 : flen + 1;
            end
        end
        idleCycles(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_pe_array.md
# conv_pe_array

Parametrised processing-element array for the convolution layers: KPF output-kernel lanes, each a CPF-wide signed multiply-accumulate against one shared input vector. It accumulates over a beat stream delimited by `op_din_eop`, adds per-lane bias, rescales with rounding and saturation, and applies a selectable activation. It sits between the layer controller/RAMs and the output blob packer, and replaces the per-lane fixed-function MAC instances with one block. Over the earlier design it adds a registered output strobe, a leaky-ReLU mode and a sticky saturation flag.

## Interface
- `CPF`, 8, input channels per beat (≥1)
- `KPF`, 4, kernel lanes (≥1)
- `DIN_DW`, 16, signed input element width
- `WW`, 16, signed weight element width
- `BIAS_DW`, 16, signed bias width
- `DOUT_DW`, 16, signed output width
- `ACC_WIDTH`, 40, signed accumulator width (≥ DIN_DW+WW+clog2(CPF)+1)
- `DIN_Q`, 6, input fractional bits
- `W_Q`, 13, weight fractional bits
- `BIAS_Q`, 6, bias fractional bits (≤ DIN_Q+W_Q)
- `DOUT_Q`, 6, output fractional bits (< DIN_Q+W_Q)
- `ACT_MODE`, 1, 0 = none, 1 = ReLU, 2 = leaky ReLU (negative >>> 3)

Ports:
- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `op_din_en` in 1: input beat valid
- `op_din_eop` in 1: last beat of the accumulation frame; qualified by `op_din_en`
- `op_din` in CPF*DIN_DW: input vector, element c at [c*DIN_DW +: DIN_DW]
- `op_weight` in KPF*CPF*WW: lane k, element c at [(k*CPF+c)*WW +: WW]
- `op_bias` in KPF*BIAS_DW: lane k bias; sampled with the eop beat
- `op_dout` out KPF*DOUT_DW: lane k result at [k*DOUT_DW +: DOUT_DW]; held between strobes
- `op_dout_en` out 1: one-cycle strobe, `op_dout` valid
- `sat_flag` out 1: sticky; set when any lane saturates

## Operation
- Pipeline per lane:
  - S1: register CPF products.
  - S2: register the lane sum of products, sign-extended to ACC_WIDTH.
  - S3: accumulate.
  - S4: finish and register the output.
- The valid, eop and first flags travel with the data through the stages. `first` is 1 on the first beat after reset or after an eop beat.
- S3 update: `acc <= first ? sum : acc + sum`. A new frame never inherits a previous partial sum, even when frames are back-to-back.
- S4 runs only for the eop beat and uses the bias registered at S1 alongside that beat:
  - `t = acc + (bias <<< (DIN_Q+W_Q-BIAS_Q))`
  - `r = (t + 2^(SH-1)) >>> SH`, with SH = DIN_Q+W_Q-DOUT_Q (round half up)
  - Activation on r:
    - mode 1: r < 0 gives 0.
    - mode 2: r < 0 gives r >>> 3 (arithmetic).
  - Saturate to signed DOUT_DW range [−2^(DOUT_DW−1), 2^(DOUT_DW−1)−1].
- If any lane clamps in S4, `sat_flag` is set to 1. It clears only on `rst`.
- Beats without `op_din_en` are ignored entirely; their data, weight, bias and eop are all don't-care.
- A single-beat frame (`en` and `eop` together, first beat) is legal.
- Arithmetic is internal to the wide datapath. The accumulator itself wraps and is not checked; sizing it correctly is the integrator's responsibility.

## Timing
- Beat with eop accepted at edge t gives `op_dout_en` = 1 for exactly the cycle after edge t+4. Fixed latency is 4 and independent of frame length.
- Throughput is one beat per cycle with no backpressure. Back-to-back eop beats give back-to-back strobes.
- `op_dout` updates only at the strobe and holds until the next strobe.
- Reset values: `op_dout` = 0, `op_dout_en` = 0, `sat_flag` = 0. All stage valid flags and accumulators are 0 and `first` = 1.
- `rst` asserted mid-frame: all in-flight beats and partial sums are discarded and no strobe is produced for them. The first beat after release starts a new frame.
- Input `op_din_en` during `rst` is ignored.

## Test plan
Defaults are used unless stated.
- **Basic:** single beat with eop; `op_din` all 64 (1.0); lane0 weights all 8192 (1.0), other lanes 0; bias 0 → strobe 4 cycles later. Lane0 = 512 (8.0), others 0, `sat_flag` = 0.
- **Activation:** same as basic, lane0 weights all −8192.
  - ACT_MODE=1 → lane0 = 0.
  - ACT_MODE=2 → lane0 = −64.
  - ACT_MODE=0 → lane0 = −512.
- **Rounding and bias:** element0 = 1, lane0 weight0 = 4096, all else 0, lane0 bias = 64, single beat → lane0 = 65 (64.5 rounded up).
- **Saturation:** 4-beat frame with `op_din` and weights all 32767 → every lane 32767, `sat_flag` = 1. `sat_flag` stays 1 after a following non-saturating frame until `rst`.
- **Back-to-back frames:** frame A is 3 basic beats (eop on cycle 2); frame B is 1 beat with weights 4096 on cycle 3.
  - Strobes on cycles 6 and 7.
  - Lane0 = 1536 for A, then 256 for B (B has no carry-over from A).
- **Reset mid-frame:** 2 basic beats, pulse `rst` 1 cycle, then 1 basic eop beat.
  - No strobe for the aborted frame.
  - One strobe with lane0 = 512.
  - `op_dout` reads 0 between the reset and that strobe.
